// File: rtl/bpu_upd_queue.sv
// ---------------------------------------------------------------------------
// bpu_upd_queue
//
// Buffers resolved taken branches from the backend and drains them into the
// BTB one entry per cycle. Not-taken branches are accepted and dropped. A
// taken branch whose PC matches the newest queued entry refreshes that entry
// in place, so the latest target/type wins and queue slots are not wasted.
//
// Parameters
//   DEPTH        number of entries (power of two, 2..16)
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-high reset
//   in_valid     resolved branch presented
//   in_ready     queue can accept in_* this cycle
//   in_pc        resolved branch PC [31:2]
//   in_target    resolved branch target [31:2]
//   in_br_type   branch type (BTB Br_type encoding)
//   in_taken     branch resolved taken
//   wr_hold      forbids a BTB write this cycle
//   btb_we       BTB write enable (pops the head at the edge)
//   btb_wpc      BTB write PC (head entry)
//   btb_bta      BTB write target (head entry)
//   btb_br_type  BTB write type (head entry)
//   count        current occupancy
// ---------------------------------------------------------------------------
module bpu_upd_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:2]              in_pc,
    input  logic [31:2]              in_target,
    input  logic [1:0]               in_br_type,
    input  logic                     in_taken,
    input  logic                     wr_hold,
    output logic                     btb_we,
    output logic [31:2]              btb_wpc,
    output logic [31:2]              btb_bta,
    output logic [1:0]               btb_br_type,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Pointer and occupancy state
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Payload storage; contents are only meaningful below count, so no reset
    logic [31:2] pc_mem_q   [DEPTH];
    logic [31:2] tgt_mem_q  [DEPTH];
    logic [1:0]  type_mem_q [DEPTH];

    // Control decode
    logic             empty_s;
    logic             full_s;
    logic             pop_s;
    logic             accept_s;
    logic             taken_acc_s;
    logic             newest_match_s;
    logic             newest_leaving_s;
    logic             coalesce_s;
    logic             store_s;
    logic [PTR_W-1:0] newest_idx_s;

    // Decode push/pop/coalesce decisions from registered state and inputs
    always_comb begin
        empty_s      = (count_q == {CNT_W{1'b0}});
        full_s       = (count_q == FULL_CNT);
        newest_idx_s = tail_q - PTR_W'(1);

        // A write is never issued while reset is high; this also suppresses
        // the pop of a drain that is interrupted by reset.
        pop_s        = ~reset & ~empty_s & ~wr_hold;
        accept_s     = in_valid & in_ready;
        taken_acc_s  = ~reset & accept_s & in_taken;

        newest_match_s   = ~empty_s & (pc_mem_q[newest_idx_s] == in_pc);
        // With a single entry, the newest entry is also the head; if it is
        // being written to the BTB now, refreshing it would be lost.
        newest_leaving_s = pop_s & (count_q == CNT_W'(1));

        coalesce_s = taken_acc_s & newest_match_s & ~newest_leaving_s;
        store_s    = taken_acc_s & ~coalesce_s;
    end

    // Next-state for pointers and occupancy
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (pop_s) begin
            head_d = head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end

        if (store_s) begin
            tail_d = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end

        case ({store_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload write: new entry at the tail, or in-place refresh of the newest
    always_ff @(posedge clk) begin
        if (store_s) begin
            pc_mem_q[tail_q]   <= in_pc;
            tgt_mem_q[tail_q]  <= in_target;
            type_mem_q[tail_q] <= in_br_type;
        end else if (coalesce_s) begin
            tgt_mem_q[newest_idx_s]  <= in_target;
            type_mem_q[newest_idx_s] <= in_br_type;
        end
    end

    // Outputs depend only on registered state (plus reset/wr_hold gating)
    always_comb begin
        in_ready    = reset | ~full_s;
        btb_we      = pop_s;
        btb_wpc     = pc_mem_q[head_q];
        btb_bta     = tgt_mem_q[head_q];
        btb_br_type = type_mem_q[head_q];
        count       = count_q;
    end

endmodule

// File: tb/tb_bpu_upd_queue.sv
module tb_bpu_upd_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:2] in_pc;
    logic [31:2] in_target;
    logic [1:0]  in_br_type;
    logic        in_taken;
    logic        wr_hold;
    logic        btb_we;
    logic [31:2] btb_wpc;
    logic [31:2] btb_bta;
    logic [1:0]  btb_br_type;
    logic [2:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    bpu_upd_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_target   (in_target),
        .in_br_type  (in_br_type),
        .in_taken    (in_taken),
        .wr_hold     (wr_hold),
        .btb_we      (btb_we),
        .btb_wpc     (btb_wpc),
        .btb_bta     (btb_bta),
        .btb_br_type (btb_br_type),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: a plain queue of entries ----------
    typedef struct {
        logic [29:0] pc;
        logic [29:0] tgt;
        logic [1:0]  ty;
    } ent_t;

    ent_t mq[$];

    task automatic model_update();
        ent_t e;
        bit   pop;
        bit   acc;
        if (reset) begin
            mq.delete();
        end else begin
            pop = (mq.size() != 0) && !wr_hold;
            acc = in_valid && (mq.size() != DEPTH);
            if (acc && in_taken) begin
                if (mq.size() != 0 && mq[mq.size()-1].pc == in_pc &&
                    !(pop && mq.size() == 1)) begin
                    mq[mq.size()-1].tgt = in_target;
                    mq[mq.size()-1].ty  = in_br_type;
                end else begin
                    e.pc  = in_pc;
                    e.tgt = in_target;
                    e.ty  = in_br_type;
                    mq.push_back(e);
                end
            end
            if (pop) void'(mq.pop_front());
        end
    endtask

    // ---------------- helpers ---------------------------------------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic apply(input logic rst, input logic v, input logic [29:0] pc,
                         input logic [29:0] tgt, input logic [1:0] ty,
                         input logic tk, input logic hold);
        @(negedge clk);
        reset      = rst;
        in_valid   = v;
        in_pc      = pc;
        in_target  = tgt;
        in_br_type = ty;
        in_taken   = tk;
        wr_hold    = hold;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    // ---------------- directed vector table -------------------------------
    typedef struct {
        logic        rst;
        logic        v;
        logic [29:0] pc;
        logic [29:0] tgt;
        logic [1:0]  ty;
        logic        tk;
        logic        hold;
        logic [2:0]  ecnt;
        logic        ewe;
        logic        erdy;
        logic [29:0] ewpc;
        logic [29:0] ebta;
        logic [1:0]  ety;
        logic        chk;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic v, input logic [29:0] pc,
                       input logic [29:0] tgt, input logic [1:0] ty, input logic tk,
                       input logic hold, input logic [2:0] ecnt, input logic ewe,
                       input logic erdy, input logic [29:0] ewpc,
                       input logic [29:0] ebta, input logic [1:0] ety, input logic c);
        vec_t r;
        r.rst = rst; r.v = v; r.pc = pc; r.tgt = tgt; r.ty = ty; r.tk = tk;
        r.hold = hold; r.ecnt = ecnt; r.ewe = ewe; r.erdy = erdy;
        r.ewpc = ewpc; r.ebta = ebta; r.ety = ety; r.chk = c;
        vecs.push_back(r);
    endtask

    localparam logic [29:0] PA  = 30'h400;   // 0x1000 >> 2
    localparam logic [29:0] TA  = 30'h800;   // 0x2000 >> 2
    localparam logic [29:0] T1  = 30'h900;
    localparam logic [29:0] T2  = 30'hA00;
    localparam logic [29:0] T3  = 30'hB00;
    localparam logic [29:0] PB  = 30'h123;
    localparam logic [29:0] Z30 = 30'h0;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_pc = Z30; in_target = Z30;
        in_br_type = 2'd0; in_taken = 1'b0; wr_hold = 1'b0;

        //   rst  v     pc      tgt     ty    tk    hold  cnt  we    rdy   wpc     bta     ty    chk
        // reset state
        add(1'b1, 1'b0, Z30,    Z30,    2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, Z30,    Z30,    2'd0, 1'b0);
        add(1'b1, 1'b0, Z30,    Z30,    2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, Z30,    Z30,    2'd0, 1'b1);
        add(1'b0, 1'b0, Z30,    Z30,    2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, Z30,    Z30,    2'd0, 1'b1);
        // single taken input
        add(1'b0, 1'b1, PA,     TA,     2'd1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, Z30,    Z30,    2'd0, 1'b1);
        add(1'b0, 1'b0, Z30,    Z30,    2'd0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, PA,     TA,     2'd1, 1'b1);
        add(1'b0, 1'b0, Z30,    Z30,    2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, Z30,    Z30,    2'd0, 1'b1);
        // not-taken inputs are dropped
        add(1'b0, 1'b1, PB,     T1,     2'd2, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, Z30,    Z30,    2'd0, 1'b1);
        add(1'b0, 1'b1, PB,     T1,     2'd2, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, Z30,    Z30,    2'd0, 1'b1);
        add(1'b0, 1'b1, PB,     T1,     2'd2, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, Z30,    Z30,    2'd0, 1'b1);
        add(1'b0, 1'b0, Z30,    Z30,    2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, Z30,    Z30,    2'd0, 1'b1);
        // fill under hold, fifth input refused, then drain in order
        add(1'b0, 1'b1, 30'h10, 30'h110, 2'd0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, Z30,   Z30,    2'd0, 1'b1);
        add(1'b0, 1'b1, 30'h20, 30'h120, 2'd1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, Z30,   Z30,    2'd0, 1'b1);
        add(1'b0, 1'b1, 30'h30, 30'h130, 2'd2, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, Z30,   Z30,    2'd0, 1'b1);
        add(1'b0, 1'b1, 30'h40, 30'h140, 2'd3, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, Z30,   Z30,    2'd0, 1'b1);
        add(1'b0, 1'b1, 30'h50, 30'h150, 2'd0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, Z30,   Z30,    2'd0, 1'b1);
        add(1'b0, 1'b0, Z30,    Z30,     2'd0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 30'h10, 30'h110, 2'd0, 1'b1);
        add(1'b0, 1'b0, Z30,    Z30,     2'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 30'h20, 30'h120, 2'd1, 1'b1);
        add(1'b0, 1'b0, Z30,    Z30,     2'd0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 30'h30, 30'h130, 2'd2, 1'b1);
        add(1'b0, 1'b0, Z30,    Z30,     2'd0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 30'h40, 30'h140, 2'd3, 1'b1);
        add(1'b0, 1'b0, Z30,    Z30,     2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, Z30,    Z30,    2'd0, 1'b1);
        // coalesce under hold
        add(1'b0, 1'b1, PA,     T1,     2'd2, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, Z30,    Z30,    2'd0, 1'b1);
        add(1'b0, 1'b1, PA,     T2,     2'd3, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, Z30,    Z30,    2'd0, 1'b1);
        add(1'b0, 1'b0, Z30,    Z30,    2'd0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, PA,     T2,     2'd3, 1'b1);
        add(1'b0, 1'b0, Z30,    Z30,    2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, Z30,    Z30,    2'd0, 1'b1);
        // pop/push race on a single matching entry
        add(1'b0, 1'b1, PA,     T1,     2'd1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, Z30,    Z30,    2'd0, 1'b1);
        add(1'b0, 1'b1, PA,     T3,     2'd0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, PA,     T1,     2'd1, 1'b1);
        add(1'b0, 1'b0, Z30,    Z30,    2'd0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, PA,     T3,     2'd0, 1'b1);
        add(1'b0, 1'b0, Z30,    Z30,    2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, Z30,    Z30,    2'd0, 1'b1);
        // reset mid-drain
        add(1'b0, 1'b1, 30'h10, 30'h110, 2'd0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, Z30,   Z30,    2'd0, 1'b1);
        add(1'b0, 1'b1, 30'h20, 30'h120, 2'd1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, Z30,   Z30,    2'd0, 1'b1);
        add(1'b0, 1'b1, 30'h30, 30'h130, 2'd2, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, Z30,   Z30,    2'd0, 1'b1);
        add(1'b0, 1'b0, Z30,    Z30,     2'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 30'h10, 30'h110, 2'd0, 1'b1);
        add(1'b1, 1'b0, Z30,    Z30,     2'd0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, Z30,   Z30,    2'd0, 1'b1);
        add(1'b0, 1'b0, Z30,    Z30,     2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, Z30,   Z30,    2'd0, 1'b1);
        add(1'b0, 1'b0, Z30,    Z30,     2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, Z30,   Z30,    2'd0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].v, vecs[i].pc, vecs[i].tgt, vecs[i].ty,
                  vecs[i].tk, vecs[i].hold);
            if (vecs[i].chk) begin
                chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].ecnt));
                chk($sformatf("vec%0d_we", i), 32'(btb_we), 32'(vecs[i].ewe));
                chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vecs[i].erdy));
                if (vecs[i].ewe) begin
                    chk($sformatf("vec%0d_wpc", i), 32'(btb_wpc), 32'(vecs[i].ewpc));
                    chk($sformatf("vec%0d_bta", i), 32'(btb_bta), 32'(vecs[i].ebta));
                    chk($sformatf("vec%0d_type", i), 32'(btb_br_type), 32'(vecs[i].ety));
                end
            end
            tick();
        end

        // ---------------- randomized phase against the queue model -------
        for (int c = 0; c < 3000; c++) begin
            logic        r_rst;
            logic [29:0] r_pc;
            r_rst = ($urandom_range(0, 99) == 0);
            r_pc  = 30'h100 + 30'($urandom_range(0, 3));
            apply(r_rst, ($urandom_range(0, 3) != 0), r_pc, 30'($urandom),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) < 4));
            chk("rnd_count", 32'(count), 32'(mq.size()));
            chk("rnd_ready", 32'(in_ready), 32'(reset || mq.size() != DEPTH));
            chk("rnd_we", 32'(btb_we), 32'(!reset && mq.size() != 0 && !wr_hold));
            if (!reset && mq.size() != 0 && !wr_hold) begin
                chk("rnd_wpc", 32'(btb_wpc), 32'(mq[0].pc));
                chk("rnd_bta", 32'(btb_bta), 32'(mq[0].tgt));
                chk("rnd_type", 32'(btb_br_type), 32'(mq[0].ty));
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bpu_upd_queue.md
BPU_UPD_QUEUE -- requirements
Module: bpu_upd_queue

Interface
REQ-001 The block SHALL take parameter DEPTH, default 4, as the number of queue entries (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit, as the clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, as the reset: synchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit, which flags that a resolved branch from the backend is presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit, which signals that the queue accepts in_* this cycle.
REQ-006 The block SHALL have port in_pc, input, [31:2], as the resolved branch PC.
REQ-007 The block SHALL have port in_target, input, [31:2], as the resolved branch target.
REQ-008 The block SHALL have port in_br_type, input, [1:0], as the branch type, same encoding as the BTB Br_type field.
REQ-009 The block SHALL have port in_taken, input, 1 bit, which flags that the branch resolved taken.
REQ-010 The block SHALL have port wr_hold, input, 1 bit, which, when high, forbids a BTB write this cycle.
REQ-011 The block SHALL have port btb_we, output, 1 bit, as the BTB write enable.
REQ-012 The block SHALL have port btb_wpc, output, [31:2], as the BTB write PC.
REQ-013 The block SHALL have port btb_bta, output, [31:2], as the BTB write target.
REQ-014 The block SHALL have port btb_br_type, output, [1:0], as the BTB write type.
REQ-015 The block SHALL have port count, output, $clog2(DEPTH)+1 bits, as the current occupancy.

Function
REQ-016 The block SHALL accept an input when in_valid and in_ready are both high; this is an accept.
REQ-017 The block SHALL drive in_ready = (count != DEPTH); it depends only on registered state, with no same-cycle pop bypass.
REQ-018 On an accept with in_taken=0, the block SHALL discard the input and leave the queue unchanged.
REQ-019 On an accept with in_taken=1, the block SHALL store {in_pc, in_target, in_br_type} at the tail, unless REQ-020 applies.
REQ-020 The block SHALL coalesce an input instead of storing it when all hold: taken accept, count>=1, in_pc equals the newest entry's PC, and that entry is not popped this cycle.
- Coalesce: overwrite that entry's target and type in place; count unchanged.
REQ-021 When count==1 and the head is popped in the same cycle, the block SHALL NOT coalesce; a matching input is stored as a new entry.
REQ-022 The block SHALL drive btb_we = (count != 0) & ~wr_hold, combinationally from registered state.
REQ-023 The block SHALL drive btb_wpc, btb_bta and btb_br_type from the head entry at all times; their value is don't-care when btb_we=0.
REQ-024 When btb_we=1, the block SHALL pop the head at the clock edge (head pointer +1).
REQ-025 When wr_hold=1, the block SHALL keep the head and its contents stable.
REQ-026 Write latency: an input stored at edge N SHALL reach btb_we, at the earliest, in the cycle after edge N; there is no input-to-output combinational path.
REQ-027 On a simultaneous store and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-028 The head and tail pointers SHALL wrap modulo DEPTH.
REQ-029 Full/empty SHALL be derived from count only.
REQ-030 Entries SHALL leave in FIFO order; coalescing never reorders entries.
REQ-031 count SHALL equal the number of entries stored minus the number popped since reset; it never exceeds DEPTH and never underflows.

Reset
REQ-032 When reset is high at a clock edge, the block SHALL set count=0 and both pointers to 0, dropping all pending entries.
REQ-033 While reset is high, and on the first cycle after it, the block SHALL drive btb_we=0 and in_ready=1.
REQ-034 When reset is asserted mid-drain, the block SHALL suppress the pop in that cycle, and no further writes SHALL occur until new inputs are stored.
REQ-035 Entry payload storage SHALL NOT require reset.

Verification
REQ-036 Single taken input: pc=0x1000>>2, target=0x2000>>2, type=1, wr_hold=0 -> next cycle btb_we=1 with matching fields, count returns to 0 one cycle later.
REQ-037 Not-taken input: in_taken=0 for 3 cycles -> count stays 0 and btb_we stays 0.
REQ-038 Fill: wr_hold=1, 4 distinct taken PCs -> count=4 and in_ready=0; a fifth input is not accepted; release wr_hold -> 4 writes on consecutive cycles in input order.
REQ-039 Coalesce: wr_hold=1, push pc A target T1, then pc A target T2 -> count=1; release -> exactly one write, with bta=T2.
REQ-040 Pop/push race: count=1 (pc A), wr_hold=0, push pc A target T3 -> head A is written this cycle, count stays 1, and the next write is A/T3.
REQ-041 Reset mid-drain: count=3, assert reset one cycle -> count=0 and btb_we=0 afterwards, and no stale write appears.
